// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared types and panel constants for the tft draw arbiter
package tft_pkg;

  localparam int TFT_XMAX = 239;
  localparam int TFT_YMAX = 319;

  typedef struct packed {
    logic [15:0] color;
    logic [15:0] xstart;
    logic [15:0] ystart;
    logic [15:0] xend;
    logic [15:0] yend;
  } tft_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // End coordinates are clamped to the panel; start coordinates are only judged, never altered.
  function automatic tft_cmd_t clip_cmd(input tft_cmd_t c, input int xmax, input int ymax);
    tft_cmd_t r;
    r = c;
    if (r.xend > 16'(xmax)) r.xend = 16'(xmax);
    if (r.yend > 16'(ymax)) r.yend = 16'(ymax);
    return r;
  endfunction

  function automatic logic cmd_off_panel(input tft_cmd_t c, input int xmax, input int ymax);
    return (c.xstart > 16'(xmax)) || (c.ystart > 16'(ymax));
  endfunction

endpackage

// File: rtl/tft_rr_pick.sv
// rtl/tft_rr_pick.sv - combinational round-robin selector: first requester after ptr_i wins
module tft_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int  i;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      i = int'(ptr_i) + k;
      if (i >= NREQ) i = i - NREQ;
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = PW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/tft_draw_arbiter.sv
// rtl/tft_draw_arbiter.sv - round-robin owner of the tft_ctrl draw port with watchdog
// Optional coordinate clipping and off-panel rejection when TFT_ARB_CLIP_EN is defined.
module tft_draw_arbiter #(
  parameter int NREQ     = 4,
  parameter int CMD_W    = 80,
  parameter int TFT_XMAX = tft_pkg::TFT_XMAX,
  parameter int TFT_YMAX = tft_pkg::TFT_YMAX,
  parameter int TMO_W    = 20
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CMD_W-1:0] cmd,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done_o,
  output logic [NREQ-1:0]       cnext_o,
  output logic                  tft_draw,
  output logic [CMD_W-1:0]      tft_cmd,
  input  logic                  tft_busy,
  input  logic                  tft_done,
  input  logic                  tft_cnext,
  output logic                  err_timeout
);
  import tft_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  tft_cmd_t          sel_c;
  logic [CMD_W-1:0]  lat_cmd;
  logic              reject;
  logic [TMO_W-1:0]  tmo_inc;
  logic              expire;

  tft_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_c = tft_cmd_t'(cmd[pick_idx*CMD_W +: CMD_W]);
`ifdef TFT_ARB_CLIP_EN
    lat_cmd = CMD_W'(clip_cmd(sel_c, TFT_XMAX, TFT_YMAX));
    reject  = cmd_off_panel(sel_c, TFT_XMAX, TFT_YMAX);
`else
    lat_cmd = CMD_W'(sel_c);
    reject  = 1'b0;
`endif
  end

  // The watchdog fires at the end of the (2**TMO_W-1)-th ISSUE cycle.
  assign tmo_inc = tmo_q + TMO_W'(1);
  assign expire  = &tmo_inc;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && !tft_busy) begin
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          cmd_d   = lat_cmd;
          tmo_d   = '0;
          state_d = reject ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = tmo_inc;
        // A completion in the expiry cycle wins over the timeout.
        if (tft_done) begin
          state_d = DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = owner_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt         = gnt_q;
    tft_cmd     = cmd_q;
    tft_draw    = (state_q == ISSUE);
    done_o      = (state_q == DONE) ? gnt_q : '0;
    cnext_o     = gnt_q & {NREQ{tft_cnext}};
    err_timeout = err_q;
  end

endmodule
